sync_stable_multibit: RTL

Parametrised multi-bit capture stage for a bus arriving asynchronously with per-bit skew.
- Each bit passes through its own SYNC_STAGES flop synchroniser.
- A stability filter then releases a new word only after it has held unchanged for STABLE_CYCLES consecutive samples. Intermediate, incoherent mixes of old and new bits therefore never reach the output.
- Aborted settling windows are counted for observability.
- Sits at the receive side of any slow-changing multi-bit crossing (config words, gray-free counters, status buses).

---
 rtl/sync_stable_multibit_pkg.sv | 20 ++
 rtl/sync_multibit.sv | 24 ++
 rtl/sync_stable_multibit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sync_stable_multibit_pkg.sv
// Shared definitions for the stable multi-bit capture stage.
package sync_stable_multibit_pkg;

  // Filter FSM states: waiting for a change, or qualifying a candidate word.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  // Ceiling log2 for sizing counters from parameters (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_multibit.sv
// Per-bit flop synchroniser chains; no cross-bit coherency is attempted here.
module sync_multibit #(
  parameter int NB          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic [NB-1:0] i_data,
  output logic [NB-1:0] o_data
);

  for (genvar b = 0; b < NB; b++) begin : g_bit
    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous bit through its own chain; chain[0] is the first stage.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) chain <= '0;
      else            chain <= {chain[SYNC_STAGES-2:0], i_data[b]};
    end

    assign o_data[b] = chain[SYNC_STAGES-1];
  end

endmodule

// File: rtl/sync_stable_multibit.sv
// Multi-bit receive stage: per-bit synchronisers followed by a stability filter
// that only releases a word after it has held for STABLE_CYCLES samples, so
// skewed partial updates never appear at the output.
module sync_stable_multibit
  import sync_stable_multibit_pkg::*;
#(
  parameter int NB            = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int NB_CNT        = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [NB-1:0]     i_data,
  input  logic              i_clear_cnt,
  output logic [NB-1:0]     o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic [NB_CNT-1:0] o_abort_cnt
);

  localparam int                CNT_W      = clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(STABLE_CYCLES);

  logic [NB-1:0]    sync_q;
  logic [NB-1:0]    cand;
  logic [NB-1:0]    out_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             load_out;
  logic             load_cand;
  logic             abort;
  state_t           state;
  state_t           state_next;

  sync_multibit #(
    .NB          (NB),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_data    (i_data),
    .o_data    (sync_q)
  );

  assign cnt_inc = cnt + CNT_ONE;
  assign o_busy  = (state == ST_SETTLE);

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next state and datapath controls; any change of the synchronised word while
  // settling restarts qualification and counts as an abort.
  always_comb begin
    state_next = state;
    out_next   = o_data;
    load_out   = 1'b0;
    load_cand  = 1'b0;
    cnt_next   = cnt;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_q != o_data) begin
          if (STABLE_CYCLES == 1) begin
            load_out = 1'b1;
            out_next = sync_q;
          end else begin
            load_cand  = 1'b1;
            cnt_next   = CNT_ONE;
            state_next = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (sync_q == cand) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_TARGET) begin
            load_out   = 1'b1;
            out_next   = cand;
            state_next = ST_IDLE;
          end
        end else begin
          abort = 1'b1;
          if (sync_q == o_data) begin
            state_next = ST_IDLE;
          end else begin
            load_cand = 1'b1;
            cnt_next  = CNT_ONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output word, valid pulse, candidate and stable counter.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      cand    <= '0;
      cnt     <= '0;
    end else begin
      o_data  <= out_next;
      o_valid <= load_out;
      cnt     <= cnt_next;
      if (load_cand) cand <= sync_q;
    end
  end

  // Saturating abort counter; a clear takes priority over a coincident abort.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                         o_abort_cnt <= '0;
    else if (i_clear_cnt)                   o_abort_cnt <= '0;
    else if (abort && (o_abort_cnt != '1))  o_abort_cnt <= o_abort_cnt + 1'b1;
  end

endmodule
